eth_rx_udp_filter: RTL and testbench
====================================

// Module: eth_rx_udp_filter
// PURPOSE
//  Store-and-forward filter directly downstream of the 10G MAC RX AXI-Stream (m_axis_rx_*), 64-bit, byte0 = tdata[7:0].
//  Accepts only good IPv4/UDP frames addressed to UDP_PORT and forwards them whole to the NetTLP decap stage.
//  Rejected, errored and overflowed frames are discarded without any beat reaching the output.
// PARAMETERS
//  DEPTH     512     FIFO depth in 64-bit beats, power of two, >= 16
//  UDP_PORT  16'h3000 accepted UDP destination port
// PORTS
//  clk156         in   1   156.25 MHz clock
//  sys_rst156_n   in   1   async active-low reset
//  s_axis_tvalid  in   1   MAC RX valid; no tready, the MAC cannot be stalled
//  s_axis_tlast   in   1   last beat of frame
//  s_axis_tkeep   in   8   byte enables, contiguous from bit 0
//  s_axis_tdata   in   64  frame data
//  s_axis_tuser   in   1   sampled on tlast beat: 1 = good FCS/frame
//  m_axis_tready  in   1   downstream ready
//  m_axis_tvalid  out  1   output valid
//  m_axis_tlast   out  1   output last
//  m_axis_tkeep   out  8   output byte enables
//  m_axis_tdata   out  64  output data
//  cnt_pass       out  32  frames forwarded
//  cnt_drop_err   out  32  frames dropped, tuser=0
//  cnt_drop_flt   out  32  frames dropped, header mismatch or frame < 5 beats
//  cnt_drop_ovf   out  32  frames dropped, FIFO full
// BEHAVIOUR
//  Reset: m_axis_tvalid=0, tlast=0, tkeep=0, tdata=0, all counters 0, all pointers 0, state IDLE.
//  Reset mid-frame discards the frame and all uncommitted beats; input resumes at the next tvalid after deassertion.
//  Pointers wr/commit/rd are log2(DEPTH)+1 bits. full = (wr - rd == DEPTH); empty = (rd == commit).
//  Write FSM states:
//   IDLE: a tvalid beat starts a frame (-> RECV) and is written; beat counter = 1.
//   RECV: writes every tvalid beat. If full on a tvalid beat, that beat is not written (-> DROP).
//   DROP: ignores beats until tlast (-> IDLE); wr rewinds to commit; cnt_drop_ovf++.
//  Header check latches per beat index, assuming IHL=5:
//   beat1: bytes 12-13 (tdata[39:32],[47:40]) == 08 00; byte 14 (tdata[55:48]) == 8'h45.
//   beat2: byte 23 (tdata[63:56]) == 8'h11.
//   beat4: bytes 36-37 (tdata[39:32]=MSB,[47:40]=LSB) == UDP_PORT.
//  Action on the tlast beat in RECV (the tlast beat itself is written), priority order:
//   1. tuser=0: rewind wr to commit; cnt_drop_err++.
//   2. fewer than 5 beats or any check fails: rewind; cnt_drop_flt++.
//   3. Otherwise: commit <= wr+1; cnt_pass++.
//  tlast on a beat that starts the frame (1-beat frame): handled as in RECV, giving cnt_drop_flt or cnt_drop_err.
//  Latency: tlast beat written in cycle N, commit visible at N+1, first beat on m_axis at N+2 if the FIFO was empty.
//  Read side: standard AXIS through a one-entry output register.
//   - Output fields are held stable while tvalid=1 and tready=0.
//   - Reads never cross commit, so output frames are always complete and contiguous.
//  Simultaneous read pop and write commit in the same cycle are both honoured; full uses the pre-pop rd value.
//  Counters wrap modulo 2^32. Each frame increments exactly one counter.
// CONFIGURATION
//  ETH_RX_UDP_FILTER_STATS_EN
//   defined: the four counters are implemented as above.
//   undefined: no counter registers; cnt_* outputs are tied to 32'd0; filtering behaviour is identical.
// TESTING
//  1. One 64-byte IPv4/UDP frame, dst port 0x3000, tuser=1, tready=1
//     -> 8 identical beats out starting 2 cycles after tlast; tkeep matches input; cnt_pass=1.
//  2. Same frame with dst port 0x3001, then tuser=0 on a matching frame
//     -> no output; cnt_drop_flt=1, cnt_drop_err=1.
//  3. EtherType 0x86DD frame, then a 3-beat frame
//     -> no output; cnt_drop_flt=2.
//  4. DEPTH=16, tready=0, two 9-beat matching frames
//     -> first committed; second hits full at beat 8 -> cnt_drop_ovf=1.
//     Release tready -> exactly 9 beats out.
//  5. Random tready (50%) under back-to-back matching frames -> byte-exact output, no lost or duplicated beats.
//     Assert sys_rst156_n low mid-frame -> outputs 0 next edge; the next frame after release passes normally.

Source files
------------

// File: rtl/eth_rx_udp_filter_if.sv
// eth_rx_udp_filter_if: 64-bit AXI-Stream bundle (byte0 = tdata[7:0]) used on both sides of the UDP filter.
// Latency: none, plain wires.
// Backpressure: tready is driven by the slave side; the MAC-facing instance is never stalled.
interface eth_rx_udp_filter_if;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [7:0]  tkeep;
  logic [63:0] tdata;
  logic        tuser;

  modport master (output tvalid, tlast, tkeep, tdata, tuser, input tready);
  modport slave  (input tvalid, tlast, tkeep, tdata, tuser, output tready);
endinterface

// File: rtl/eth_rx_udp_filter.sv
// eth_rx_udp_filter: store-and-forward filter passing only good IPv4/UDP frames sent to UDP_PORT.
// Latency: tlast beat written in cycle N, commit visible at N+1, first output beat at N+2 (empty FIFO).
// Backpressure: input cannot stall, frames that do not fit are dropped whole; output is AXIS valid/ready.
// Optional statistics: define ETH_RX_UDP_FILTER_STATS_EN to build the cnt_* counters, else they read 0.
module eth_rx_udp_filter #(
  parameter int unsigned DEPTH    = 512,
  parameter logic [15:0] UDP_PORT = 16'h3000
) (
  input  logic                       clk156,
  input  logic                       sys_rst156_n,
  eth_rx_udp_filter_if.slave         s_axis,
  eth_rx_udp_filter_if.master        m_axis,
  output logic [31:0]                cnt_pass,
  output logic [31:0]                cnt_drop_err,
  output logic [31:0]                cnt_drop_flt,
  output logic [31:0]                cnt_drop_ovf
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  // One FIFO entry: everything the output needs to rebuild a beat.
  typedef struct packed {
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } beat_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } wr_state_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  // Write side state
  wr_state_t state, state_nxt;
  ptr_t      wr_ptr, wr_nxt;
  ptr_t      commit_ptr, commit_nxt;
  logic [2:0] bcnt, bcnt_nxt;          // index of the current beat in the frame, saturates at 7
  logic      ok_eth, ok_eth_nxt;       // beat1: EtherType 0x0800 and version/IHL 0x45
  logic      ok_ip, ok_ip_nxt;         // beat2: IP protocol 0x11
  logic      ok_port, ok_port_nxt;     // beat4: UDP destination port
  logic      mem_we;
  logic      inc_pass, inc_err, inc_flt, inc_ovf;

  // Read side state
  ptr_t      rd_ptr;
  logic      out_vld;
  beat_t     out_beat;
  logic      pop;

  // Storage and derived flags
  beat_t     mem [DEPTH];
  beat_t     in_beat;
  beat_t     rd_beat;
  ptr_t      fill;
  logic      full;
  logic      eth_hit, ip_hit, port_hit;
  logic      hdr_ok;

  assign in_beat  = '{last: s_axis.tlast, keep: s_axis.tkeep, data: s_axis.tdata};
  assign rd_beat  = mem[rd_ptr[AW-1:0]];

  // Full is judged against rd before this cycle's pop so a same-cycle pop never lets a write overrun.
  assign fill     = wr_ptr - rd_ptr;
  assign full     = (fill == DEPTH_P);

  assign eth_hit  = (s_axis.tdata[39:32] == 8'h08) && (s_axis.tdata[47:40] == 8'h00) &&
                    (s_axis.tdata[55:48] == 8'h45);
  assign ip_hit   = (s_axis.tdata[63:56] == 8'h11);
  assign port_hit = ({s_axis.tdata[39:32], s_axis.tdata[47:40]} == UDP_PORT);

  // The MAC cannot be stalled; tready is only driven to keep the bundle fully defined.
  assign s_axis.tready = 1'b1;

  // Write FSM next state: frame assembly, header checks and commit/rewind decision.
  always_comb begin
    state_nxt   = state;
    wr_nxt      = wr_ptr;
    commit_nxt  = commit_ptr;
    bcnt_nxt    = bcnt;
    ok_eth_nxt  = ok_eth;
    ok_ip_nxt   = ok_ip;
    ok_port_nxt = ok_port;
    mem_we      = 1'b0;
    inc_pass    = 1'b0;
    inc_err     = 1'b0;
    inc_flt     = 1'b0;
    inc_ovf     = 1'b0;
    hdr_ok      = 1'b0;

    case (state)
      IDLE: begin
        if (s_axis.tvalid) begin
          ok_eth_nxt  = 1'b0;
          ok_ip_nxt   = 1'b0;
          ok_port_nxt = 1'b0;
          if (full) begin
            // No room even for the first beat: the whole frame is an overflow drop.
            if (s_axis.tlast) inc_ovf   = 1'b1;
            else              state_nxt = DROP;
          end else if (s_axis.tlast) begin
            // A one-beat frame is always too short; it would be written and rewound at once.
            if (!s_axis.tuser) inc_err = 1'b1;
            else               inc_flt = 1'b1;
          end else begin
            mem_we    = 1'b1;
            wr_nxt    = wr_ptr + ptr_t'(1);
            bcnt_nxt  = 3'd1;
            state_nxt = RECV;
          end
        end
      end

      RECV: begin
        if (s_axis.tvalid) begin
          if (bcnt == 3'd1) ok_eth_nxt  = eth_hit;
          if (bcnt == 3'd2) ok_ip_nxt   = ip_hit;
          if (bcnt == 3'd4) ok_port_nxt = port_hit;
          if (bcnt != 3'd7) bcnt_nxt = bcnt + 3'd1;
          hdr_ok = ok_eth_nxt && ok_ip_nxt && ok_port_nxt && (bcnt >= 3'd4);

          if (full) begin
            // Throw away everything written for this frame and swallow the rest of it.
            wr_nxt = commit_ptr;
            if (s_axis.tlast) begin
              inc_ovf   = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = DROP;
            end
          end else begin
            mem_we = 1'b1;
            wr_nxt = wr_ptr + ptr_t'(1);
            if (s_axis.tlast) begin
              state_nxt = IDLE;
              if (!s_axis.tuser) begin
                wr_nxt  = commit_ptr;
                inc_err = 1'b1;
              end else if (!hdr_ok) begin
                wr_nxt  = commit_ptr;
                inc_flt = 1'b1;
              end else begin
                commit_nxt = wr_ptr + ptr_t'(1);
                inc_pass   = 1'b1;
              end
            end
          end
        end
      end

      DROP: begin
        if (s_axis.tvalid && s_axis.tlast) begin
          inc_ovf   = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        wr_nxt    = commit_ptr;
      end
    endcase
  end

  // Write FSM registers: pointers, beat index and latched header results.
  always_ff @(posedge clk156 or negedge sys_rst156_n) begin
    if (!sys_rst156_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      bcnt       <= '0;
      ok_eth     <= 1'b0;
      ok_ip      <= 1'b0;
      ok_port    <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_nxt;
      commit_ptr <= commit_nxt;
      bcnt       <= bcnt_nxt;
      ok_eth     <= ok_eth_nxt;
      ok_ip      <= ok_ip_nxt;
      ok_port    <= ok_port_nxt;
    end
  end

  // Frame storage; contents need no reset because only committed entries are ever read.
  always_ff @(posedge clk156) begin
    if (mem_we) mem[wr_ptr[AW-1:0]] <= in_beat;
  end

  // Refill the output register whenever it is empty or being consumed, never past commit.
  assign pop = (rd_ptr != commit_ptr) && (!out_vld || m_axis.tready);

  // Output register and read pointer.
  always_ff @(posedge clk156 or negedge sys_rst156_n) begin
    if (!sys_rst156_n) begin
      rd_ptr   <= '0;
      out_vld  <= 1'b0;
      out_beat <= '0;
    end else if (pop) begin
      rd_ptr   <= rd_ptr + ptr_t'(1);
      out_vld  <= 1'b1;
      out_beat <= rd_beat;
    end else if (m_axis.tready) begin
      out_vld  <= 1'b0;
    end
  end

  assign m_axis.tvalid = out_vld;
  assign m_axis.tlast  = out_beat.last;
  assign m_axis.tkeep  = out_beat.keep;
  assign m_axis.tdata  = out_beat.data;
  // Only good frames leave this block, so the end-of-frame status is simply "good".
  assign m_axis.tuser  = out_beat.last;

`ifdef ETH_RX_UDP_FILTER_STATS_EN
  logic [31:0] pass_q, err_q, flt_q, ovf_q;

  // Per-frame outcome counters; exactly one increments per frame and all wrap.
  always_ff @(posedge clk156 or negedge sys_rst156_n) begin
    if (!sys_rst156_n) begin
      pass_q <= '0;
      err_q  <= '0;
      flt_q  <= '0;
      ovf_q  <= '0;
    end else begin
      if (inc_pass) pass_q <= pass_q + 32'd1;
      if (inc_err)  err_q  <= err_q  + 32'd1;
      if (inc_flt)  flt_q  <= flt_q  + 32'd1;
      if (inc_ovf)  ovf_q  <= ovf_q  + 32'd1;
    end
  end

  assign cnt_pass     = pass_q;
  assign cnt_drop_err = err_q;
  assign cnt_drop_flt = flt_q;
  assign cnt_drop_ovf = ovf_q;
`else
  logic unused_stats;
  assign unused_stats = ^{inc_pass, inc_err, inc_flt, inc_ovf};

  assign cnt_pass     = 32'd0;
  assign cnt_drop_err = 32'd0;
  assign cnt_drop_flt = 32'd0;
  assign cnt_drop_ovf = 32'd0;
`endif

endmodule

// File: tb/tb_eth_rx_udp_filter.sv
// tb_eth_rx_udp_filter: table vectors, hand-written latency/overflow/reset sequences and random traffic.
// Latency: checks first output beat two cycles after the tlast cycle on an empty FIFO.
// Backpressure: drives fixed or 50% random m_axis tready; input side is never stalled.
module tb_eth_rx_udp_filter;
  localparam int DEPTH = 16;

  logic        clk156 = 1'b0;
  logic        sys_rst156_n;
  logic [31:0] cnt_pass, cnt_drop_err, cnt_drop_flt, cnt_drop_ovf;

  eth_rx_udp_filter_if s_bus();
  eth_rx_udp_filter_if m_bus();

  eth_rx_udp_filter #(.DEPTH(DEPTH), .UDP_PORT(16'h3000)) dut (
    .clk156       (clk156),
    .sys_rst156_n (sys_rst156_n),
    .s_axis       (s_bus.slave),
    .m_axis       (m_bus.master),
    .cnt_pass     (cnt_pass),
    .cnt_drop_err (cnt_drop_err),
    .cnt_drop_flt (cnt_drop_flt),
    .cnt_drop_ovf (cnt_drop_ovf)
  );

  always #5 clk156 = ~clk156;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } exp_beat_t;

  // One directed vector: frame fields in, expected outcome out (0 pass, 1 err, 2 flt).
  typedef struct {
    int          len;
    logic [15:0] etype;
    logic [7:0]  verihl;
    logic [7:0]  proto;
    logic [15:0] port;
    logic        user;
    int          cat;
  } vec_t;

  exp_beat_t   exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          rx_beats = 0;
  int          m_cnt[4];           // model counts: pass, err, flt, ovf
  logic [7:0]  fr[128];
  int          fr_len;
  logic        fr_user;
  bit          rdy_mode = 1'b0;
  logic        rdy_fixed = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef ETH_RX_UDP_FILTER_STATS_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n * 0);
`endif
  endfunction

  function automatic exp_beat_t beat_of(input int b);
    exp_beat_t e;
    int nb;
    int rem;
    nb  = (fr_len + 7) / 8;
    rem = fr_len - 8 * b;
    for (int k = 0; k < 8; k++) e.data[8*k +: 8] = fr[8*b + k];
    e.keep = (rem >= 8) ? 8'hFF : 8'(8'hFF >> (8 - rem));
    e.last = (b == nb - 1);
    return e;
  endfunction

  // Reference classification straight from the frame bytes.
  function automatic int classify();
    if (!fr_user) return 1;
    if (fr_len <= 32) return 2;
    if (fr[12] != 8'h08 || fr[13] != 8'h00 || fr[14] != 8'h45 || fr[23] != 8'h11 ||
        {fr[36], fr[37]} != 16'h3000) return 2;
    return 0;
  endfunction

  task automatic build_frame(input int len, input logic [15:0] etype, input logic [7:0] verihl,
                             input logic [7:0] proto, input logic [15:0] port, input logic user);
    for (int i = 0; i < 128; i++) fr[i] = 8'($urandom);
    fr[12]  = etype[15:8];
    fr[13]  = etype[7:0];
    fr[14]  = verihl;
    fr[23]  = proto;
    fr[36]  = port[15:8];
    fr[37]  = port[7:0];
    fr_len  = len;
    fr_user = user;
  endtask

  task automatic push_frame();
    for (int b = 0; b < (fr_len + 7) / 8; b++) exp_q.push_back(beat_of(b));
  endtask

  task automatic drive_beat(input int b);
    exp_beat_t e;
    e = beat_of(b);
    s_bus.tvalid = 1'b1;
    s_bus.tdata  = e.data;
    s_bus.tkeep  = e.keep;
    s_bus.tlast  = e.last;
    s_bus.tuser  = e.last ? fr_user : 1'($urandom_range(0, 1));
    @(posedge clk156);
    #1;
  endtask

  task automatic send_frame(input bit gaps);
    for (int b = 0; b < (fr_len + 7) / 8; b++) begin
      drive_beat(b);
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_bus.tvalid = 1'b0;
        s_bus.tlast  = 1'b0;
        s_bus.tdata  = {$urandom, $urandom};
        @(posedge clk156);
        #1;
      end
    end
    s_bus.tvalid = 1'b0;
    s_bus.tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 2000) begin
      @(posedge clk156);
      i++;
    end
    repeat (8) @(posedge clk156);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_cnt_pass"}, 64'(cnt_pass),     64'(exp_cnt(m_cnt[0])));
    check({tag, "_cnt_err"},  64'(cnt_drop_err), 64'(exp_cnt(m_cnt[1])));
    check({tag, "_cnt_flt"},  64'(cnt_drop_flt), 64'(exp_cnt(m_cnt[2])));
    check({tag, "_cnt_ovf"},  64'(cnt_drop_ovf), 64'(exp_cnt(m_cnt[3])));
  endtask

  // tready driver, applied a little after the edge so the main sequence's updates land first.
  initial begin
    m_bus.tready = 1'b1;
    forever begin
      @(posedge clk156);
      #2;
      m_bus.tready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Output monitor: scoreboard compare on every handshake and hold check on every stall.
  bit          stall_prev = 1'b0;
  exp_beat_t   hold;
  always @(negedge clk156) begin
    if (!sys_rst156_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        total++;
        if (!(m_bus.tvalid && m_bus.tdata == hold.data && m_bus.tkeep == hold.keep &&
              m_bus.tlast == hold.last)) begin
          bad++;
          $display("FAIL hold: got v=%b d=%h k=%h l=%b want v=1 d=%h k=%h l=%b", m_bus.tvalid,
                   m_bus.tdata, m_bus.tkeep, m_bus.tlast, hold.data, hold.keep, hold.last);
        end
      end
      if (m_bus.tvalid && m_bus.tready) begin
        rx_beats++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_beat: got unexpected d=%h k=%h l=%b want none", m_bus.tdata,
                   m_bus.tkeep, m_bus.tlast);
        end else begin
          exp_beat_t e;
          e = exp_q.pop_front();
          if (m_bus.tdata !== e.data || m_bus.tkeep !== e.keep || m_bus.tlast !== e.last) begin
            bad++;
            $display("FAIL out_beat: got d=%h k=%h l=%b want d=%h k=%h l=%b", m_bus.tdata,
                     m_bus.tkeep, m_bus.tlast, e.data, e.keep, e.last);
          end
        end
      end
      stall_prev = m_bus.tvalid && !m_bus.tready;
      hold.data  = m_bus.tdata;
      hold.keep  = m_bus.tkeep;
      hold.last  = m_bus.tlast;
    end
  end

  initial begin
    vec_t vt[14];
    int   rx0;
    int   nb;
    int   cat;
    int   i;

    vt[0]  = '{64, 16'h0800, 8'h45, 8'h11, 16'h3000, 1'b1, 0};
    vt[1]  = '{64, 16'h0800, 8'h45, 8'h11, 16'h3001, 1'b1, 2};
    vt[2]  = '{64, 16'h0800, 8'h45, 8'h11, 16'h3000, 1'b0, 1};
    vt[3]  = '{64, 16'h86DD, 8'h45, 8'h11, 16'h3000, 1'b1, 2};
    vt[4]  = '{24, 16'h0800, 8'h45, 8'h11, 16'h3000, 1'b1, 2};
    vt[5]  = '{64, 16'h0800, 8'h45, 8'h06, 16'h3000, 1'b1, 2};
    vt[6]  = '{38, 16'h0800, 8'h45, 8'h11, 16'h3000, 1'b1, 0};
    vt[7]  = '{32, 16'h0800, 8'h45, 8'h11, 16'h3000, 1'b1, 2};
    vt[8]  = '{8,  16'h0800, 8'h45, 8'h11, 16'h3000, 1'b1, 2};
    vt[9]  = '{5,  16'h0800, 8'h45, 8'h11, 16'h3000, 1'b0, 1};
    vt[10] = '{64, 16'h0800, 8'h46, 8'h11, 16'h3000, 1'b1, 2};
    vt[11] = '{67, 16'h0800, 8'h45, 8'h11, 16'h3000, 1'b1, 0};
    vt[12] = '{64, 16'h0800, 8'h45, 8'h11, 16'h0030, 1'b1, 2};
    vt[13] = '{40, 16'h0800, 8'h45, 8'h11, 16'h1234, 1'b0, 1};

    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    s_bus.tvalid = 1'b0;
    s_bus.tlast  = 1'b0;
    s_bus.tkeep  = 8'h00;
    s_bus.tdata  = 64'd0;
    s_bus.tuser  = 1'b0;
    sys_rst156_n = 1'b1;
    #2;
    sys_rst156_n = 1'b0;
    repeat (3) @(posedge clk156);
    #1;
    check("rst_tvalid", 64'(m_bus.tvalid), 64'd0);
    check("rst_tlast",  64'(m_bus.tlast),  64'd0);
    check("rst_tkeep",  64'(m_bus.tkeep),  64'd0);
    check("rst_tdata",  m_bus.tdata,       64'd0);
    check_counters("rst");
    sys_rst156_n = 1'b1;
    repeat (2) @(posedge clk156);
    #1;

    // Latency: tlast driven in cycle T, nothing at T+1, first beat visible at T+2.
    build_frame(64, 16'h0800, 8'h45, 8'h11, 16'h3000, 1'b1);
    push_frame();
    m_cnt[0]++;
    rx0 = rx_beats;
    send_frame(1'b0);
    @(negedge clk156);
    check("lat_tplus1_vld", 64'(m_bus.tvalid), 64'd0);
    @(negedge clk156);
    check("lat_tplus2_vld", 64'(m_bus.tvalid), 64'd1);
    wait_drain("lat_drain");
    check("lat_beats", 64'(rx_beats - rx0), 64'd8);
    check_counters("lat");

    // Directed vectors.
    for (int v = 0; v < 14; v++) begin
      rx0 = rx_beats;
      build_frame(vt[v].len, vt[v].etype, vt[v].verihl, vt[v].proto, vt[v].port, vt[v].user);
      if (vt[v].cat == 0) push_frame();
      m_cnt[vt[v].cat]++;
      send_frame(1'b0);
      wait_drain($sformatf("vec%0d_drain", v));
      check($sformatf("vec%0d_beats", v), 64'(rx_beats - rx0),
            64'((vt[v].cat == 0) ? (vt[v].len + 7) / 8 : 0));
      check_counters($sformatf("vec%0d", v));
    end

    // Overflow: output stalled, two back-to-back 9-beat frames; only the first fits.
    rdy_fixed = 1'b0;
    repeat (2) @(posedge clk156);
    #1;
    rx0 = rx_beats;
    build_frame(72, 16'h0800, 8'h45, 8'h11, 16'h3000, 1'b1);
    push_frame();
    m_cnt[0]++;
    send_frame(1'b0);
    build_frame(72, 16'h0800, 8'h45, 8'h11, 16'h3000, 1'b1);
    m_cnt[3]++;
    send_frame(1'b0);
    repeat (4) @(posedge clk156);
    #1;
    check("ovf_stalled_beats", 64'(rx_beats - rx0), 64'd0);
    check_counters("ovf");
    rdy_fixed = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_beats", 64'(rx_beats - rx0), 64'd9);
    rx0 = rx_beats;
    build_frame(64, 16'h0800, 8'h45, 8'h11, 16'h3000, 1'b1);
    push_frame();
    m_cnt[0]++;
    send_frame(1'b0);
    wait_drain("ovf_after_drain");
    check("ovf_after_beats", 64'(rx_beats - rx0), 64'd8);
    check_counters("ovf_after");

    // Random traffic with 50% tready, paced so the FIFO never fills.
    rdy_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int last_bytes;
      nb = int'($urandom_range(1, 12));
      last_bytes = (nb == 5) ? int'($urandom_range(6, 8)) : int'($urandom_range(1, 8));
      build_frame((nb - 1) * 8 + last_bytes, 16'h0800, 8'h45, 8'h11, 16'h3000,
                  $urandom_range(0, 7) != 0);
      case ($urandom_range(0, 9))
        0: fr[12] = 8'h86;
        1: fr[14] = 8'h46;
        2: fr[23] = 8'h06;
        3: fr[37] = 8'h01;
        4: fr[13] = 8'hDD;
        default: ;
      endcase
      i = 0;
      while (exp_q.size() + nb > DEPTH && i < 4000) begin
        @(posedge clk156);
        #1;
        i++;
      end
      if (i >= 4000) check("rnd_pace_timeout", 64'(exp_q.size()), 64'd0);
      cat = classify();
      if (cat == 0) push_frame();
      m_cnt[cat]++;
      send_frame(1'b1);
    end
    wait_drain("rnd_drain");
    check_counters("rnd");
    rdy_mode = 1'b0;
    rdy_fixed = 1'b0;

    // Reset mid-frame with a committed frame held in the output stage.
    build_frame(40, 16'h0800, 8'h45, 8'h11, 16'h3000, 1'b1);
    send_frame(1'b0);
    repeat (3) @(posedge clk156);
    #1;
    check("rst_pre_vld", 64'(m_bus.tvalid), 64'd1);
    build_frame(64, 16'h0800, 8'h45, 8'h11, 16'h3000, 1'b1);
    drive_beat(0);
    drive_beat(1);
    sys_rst156_n = 1'b0;
    s_bus.tvalid = 1'b0;
    s_bus.tlast  = 1'b0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    @(negedge clk156);
    check("midrst_tvalid", 64'(m_bus.tvalid), 64'd0);
    check("midrst_tlast",  64'(m_bus.tlast),  64'd0);
    check("midrst_tkeep",  64'(m_bus.tkeep),  64'd0);
    check("midrst_tdata",  m_bus.tdata,       64'd0);
    check_counters("midrst");
    repeat (2) @(posedge clk156);
    #1;
    sys_rst156_n = 1'b1;
    rdy_fixed = 1'b1;
    repeat (4) @(posedge clk156);
    #1;
    check("postrst_idle_vld", 64'(m_bus.tvalid), 64'd0);
    rx0 = rx_beats;
    build_frame(64, 16'h0800, 8'h45, 8'h11, 16'h3000, 1'b1);
    push_frame();
    m_cnt[0]++;
    send_frame(1'b0);
    wait_drain("postrst_drain");
    check("postrst_beats", 64'(rx_beats - rx0), 64'd8);
    check_counters("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
